// File: rtl/softmax_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : softmax_pkg
//  Description : Shared binary32 field layout, constants, FSM state type and
//                ordering helpers for the softmax front-end.
//  Revision    : 1.0 - initial release
// ============================================================================
package softmax_pkg;

    localparam int FP_SIGN_W = 1;
    localparam int FP_EXP_W  = 8;
    localparam int FP_MAN_W  = 23;
    localparam int FP_W      = FP_SIGN_W + FP_EXP_W + FP_MAN_W;

    localparam logic [FP_W-1:0] NEG_INF = 32'hFF80_0000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_REPLAY = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Maps a float onto an unsigned integer whose ordering matches the float
    // ordering, with -0 placed just below +0.
    function automatic logic [FP_W-1:0] fp_order_key(input logic [FP_W-1:0] x);
        if (x[FP_W-1])
            return ~x;
        else
            return x ^ {1'b1, {(FP_W-1){1'b0}}};
    endfunction

    function automatic logic fp_is_nan(input logic [FP_W-1:0] x);
        return (x[FP_MAN_W +: FP_EXP_W] == {FP_EXP_W{1'b1}}) &&
               (x[FP_MAN_W-1:0] != {FP_MAN_W{1'b0}});
    endfunction

endpackage
`default_nettype wire

// File: rtl/softmax_vector_buffer_fp_max_compare.sv
`default_nettype none
// ============================================================================
//  Module      : fp_max_compare
//  Description : Combinational binary32 strict greater-than and NaN detect.
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_max_compare
    import softmax_pkg::*;
(
    input  logic [FP_W-1:0] a,
    input  logic [FP_W-1:0] b,
    output logic            a_gt_b,
    output logic            a_is_nan
);

    assign a_gt_b   = fp_order_key(a) > fp_order_key(b);
    assign a_is_nan = fp_is_nan(a);

endmodule
`default_nettype wire

// File: rtl/softmax_vector_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : softmax_vector_buffer
//  Description : Loads a binary32 vector, tracks its maximum and NaN status,
//                then replays it several times over a valid/ready stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module softmax_vector_buffer
    import softmax_pkg::*;
#(
    parameter  int DATA_SIZE        = 32,
    parameter  int NUMBER_OF_DATA   = 10,
    parameter  int NUMBER_OF_PASSES = 2,
    localparam int ADDR_W           = $clog2(NUMBER_OF_DATA + 1),
    localparam int PASS_W           = (NUMBER_OF_PASSES > 1) ? $clog2(NUMBER_OF_PASSES) : 1
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic                 start_i,
    input  logic [ADDR_W-1:0]    length_i,
    input  logic                 data_valid_i,
    input  logic [DATA_SIZE-1:0] data_i,
    output logic                 load_ready_o,
    output logic                 max_valid_o,
    output logic [DATA_SIZE-1:0] max_o,
    output logic                 nan_o,
    output logic                 data_valid_o,
    input  logic                 data_ready_i,
    output logic [DATA_SIZE-1:0] data_o,
    output logic                 data_last_o,
    output logic [PASS_W-1:0]    pass_o,
    output logic                 done_o,
    output logic                 error_o,
    output logic                 busy_o
);

    localparam int                 MEM_AW    = $clog2(NUMBER_OF_DATA);
    localparam int                 PCNT_W    = $clog2(NUMBER_OF_PASSES + 1);
    localparam logic [ADDR_W-1:0]  C_MAX_LEN = ADDR_W'(NUMBER_OF_DATA);
    localparam logic [ADDR_W-1:0]  C_ONE     = ADDR_W'(1);
    localparam logic [PCNT_W-1:0]  C_PASSES  = PCNT_W'(NUMBER_OF_PASSES);
    localparam logic [PASS_W-1:0]  C_LAST_PASS = PASS_W'(NUMBER_OF_PASSES - 1);

    state_t                state_q,      state_d;
    logic [ADDR_W-1:0]     len_q,        len_d;
    logic [ADDR_W-1:0]     wr_addr_q,    wr_addr_d;
    logic [ADDR_W-1:0]     rd_addr_q,    rd_addr_d;
    logic [PCNT_W-1:0]     fetch_pass_q, fetch_pass_d;
    logic                  out_valid_q,  out_valid_d;
    logic [DATA_SIZE-1:0]  out_data_q,   out_data_d;
    logic                  out_last_q,   out_last_d;
    logic [PASS_W-1:0]     out_pass_q,   out_pass_d;
    logic [DATA_SIZE-1:0]  max_q,        max_d;
    logic                  max_valid_q,  max_valid_d;
    logic                  nan_q,        nan_d;
    logic                  error_q,      error_d;

    logic [DATA_SIZE-1:0]  mem_q [NUMBER_OF_DATA];

    logic                  w_len_ok;
    logic                  w_accept;
    logic                  w_load_beat;
    logic                  w_last_load;
    logic                  w_handshake;
    logic                  w_final_beat;
    logic                  w_refill;
    logic                  w_fetch_avail;
    logic                  w_rd_last;
    logic [DATA_SIZE-1:0]  w_rd_data;
    logic                  w_gt;
    logic                  w_is_nan;

    fp_max_compare u_cmp (
        .a        (data_i),
        .b        (max_q),
        .a_gt_b   (w_gt),
        .a_is_nan (w_is_nan)
    );

    assign w_len_ok      = (length_i != '0) && (length_i <= C_MAX_LEN);
    assign w_accept      = (state_q == ST_IDLE) && start_i && w_len_ok;
    assign w_load_beat   = (state_q == ST_LOAD) && data_valid_i;
    assign w_last_load   = w_load_beat && (wr_addr_q == len_q - C_ONE);
    assign w_handshake   = out_valid_q && data_ready_i;
    assign w_final_beat  = w_handshake && out_last_q && (out_pass_q == C_LAST_PASS);
    assign w_refill      = (state_q == ST_REPLAY) && (!out_valid_q || data_ready_i);
    assign w_fetch_avail = (fetch_pass_q != C_PASSES);
    assign w_rd_last     = (rd_addr_q == len_q - C_ONE);
    assign w_rd_data     = mem_q[rd_addr_q[MEM_AW-1:0]];

    // State register and datapath registers
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q      <= ST_IDLE;
            len_q        <= '0;
            wr_addr_q    <= '0;
            rd_addr_q    <= '0;
            fetch_pass_q <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
            out_pass_q   <= '0;
            max_q        <= '0;
            max_valid_q  <= 1'b0;
            nan_q        <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            wr_addr_q    <= wr_addr_d;
            rd_addr_q    <= rd_addr_d;
            fetch_pass_q <= fetch_pass_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_last_q   <= out_last_d;
            out_pass_q   <= out_pass_d;
            max_q        <= max_d;
            max_valid_q  <= max_valid_d;
            nan_q        <= nan_d;
            error_q      <= error_d;
        end
    end

    // Storage is left uncleared by reset; only the load path writes it.
    always_ff @(posedge clock_i) begin
        if (w_load_beat)
            mem_q[wr_addr_q[MEM_AW-1:0]] <= data_i;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (w_accept)     state_d = ST_LOAD;
            ST_LOAD:   if (w_last_load)  state_d = ST_REPLAY;
            ST_REPLAY: if (w_final_beat) state_d = ST_DONE;
            ST_DONE:                     state_d = ST_IDLE;
            default:                     state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        len_d        = len_q;
        wr_addr_d    = wr_addr_q;
        rd_addr_d    = rd_addr_q;
        fetch_pass_d = fetch_pass_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_last_d   = out_last_q;
        out_pass_d   = out_pass_q;
        max_d        = max_q;
        max_valid_d  = max_valid_q;
        nan_d        = nan_q;
        error_d      = 1'b0;

        if ((state_q == ST_IDLE) && start_i) begin
            if (w_len_ok) begin
                len_d        = length_i;
                wr_addr_d    = '0;
                rd_addr_d    = '0;
                fetch_pass_d = '0;
                out_valid_d  = 1'b0;
                out_data_d   = '0;
                out_last_d   = 1'b0;
                out_pass_d   = '0;
                max_d        = NEG_INF;
                max_valid_d  = 1'b0;
                nan_d        = 1'b0;
            end else begin
                error_d = 1'b1;
            end
        end

        if (w_load_beat) begin
            wr_addr_d = wr_addr_q + C_ONE;
            if (w_is_nan)
                nan_d = 1'b1;
            else if (w_gt)
                max_d = data_i;
            if (w_last_load)
                max_valid_d = 1'b1;
        end

        // The output register is a one-deep skid: it refills whenever it is
        // empty or its current beat is being taken, so a held-high ready
        // streams without bubbles across pass boundaries.
        if (w_refill) begin
            if (w_fetch_avail) begin
                out_valid_d = 1'b1;
                out_data_d  = w_rd_data;
                out_last_d  = w_rd_last;
                out_pass_d  = PASS_W'(fetch_pass_q);
                if (w_rd_last) begin
                    rd_addr_d    = '0;
                    fetch_pass_d = fetch_pass_q + PCNT_W'(1);
                end else begin
                    rd_addr_d    = rd_addr_q + C_ONE;
                end
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    // Output logic
    always_comb begin
        load_ready_o = (state_q == ST_LOAD);
        busy_o       = (state_q != ST_IDLE);
        done_o       = (state_q == ST_DONE);
        max_valid_o  = max_valid_q;
        max_o        = max_q;
        nan_o        = nan_q;
        data_valid_o = out_valid_q;
        data_o       = out_data_q;
        data_last_o  = out_last_q;
        pass_o       = out_pass_q;
        error_o      = error_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_softmax_vector_buffer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_softmax_vector_buffer
//  Description : Scoreboard bench for softmax_vector_buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_softmax_vector_buffer;

    localparam int N  = 10;
    localparam int P  = 2;
    localparam int DW = 32;
    localparam int AW = $clog2(N + 1);
    localparam int PW = (P > 1) ? $clog2(P) : 1;

    logic          clock_i = 1'b0;
    logic          reset_i = 1'b1;
    logic          start_i = 1'b0;
    logic [AW-1:0] length_i = '0;
    logic          data_valid_i = 1'b0;
    logic [DW-1:0] data_i = '0;
    logic          data_ready_i = 1'b1;
    logic          load_ready_o, max_valid_o, nan_o, data_valid_o, data_last_o;
    logic          done_o, error_o, busy_o;
    logic [DW-1:0] max_o, data_o;
    logic [PW-1:0] pass_o;

    softmax_vector_buffer #(.DATA_SIZE(DW), .NUMBER_OF_DATA(N), .NUMBER_OF_PASSES(P)) dut (
        .clock_i(clock_i), .reset_i(reset_i), .start_i(start_i), .length_i(length_i),
        .data_valid_i(data_valid_i), .data_i(data_i), .load_ready_o(load_ready_o),
        .max_valid_o(max_valid_o), .max_o(max_o), .nan_o(nan_o),
        .data_valid_o(data_valid_o), .data_ready_i(data_ready_i), .data_o(data_o),
        .data_last_o(data_last_o), .pass_o(pass_o), .done_o(done_o),
        .error_o(error_o), .busy_o(busy_o)
    );

    always #5 clock_i = ~clock_i;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          last;
        logic [PW-1:0] pass;
    } beat_t;

    beat_t         exp_q[$];
    int            errors = 0;
    int            checks = 0;
    int            hs_count = 0;
    int            ready_mode = 0;
    logic [DW-1:0] vec [N];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model pieces
    function automatic bit is_nan(input logic [DW-1:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 0);
    endfunction

    function automatic bit fp_greater(input logic [DW-1:0] a, input logic [DW-1:0] b);
        if (a[31] != b[31]) return b[31];
        if (!a[31]) return a[30:0] > b[30:0];
        return a[30:0] < b[30:0];
    endfunction

    function automatic logic [DW-1:0] rand_fp();
        case ($urandom_range(0, 9))
            0:       return {1'b0, 8'hFF, 1'b1, 22'($urandom)};
            1:       return {1'($urandom), 31'h0};
            2:       return {1'($urandom), 8'hFF, 23'h0};
            default: return $urandom;
        endcase
    endfunction

    // Downstream ready generator
    initial begin
        int idx = 0;
        forever begin
            @(posedge clock_i);
            #1;
            case (ready_mode)
                1:       data_ready_i = ((idx % 4) == 0) || ((idx % 4) == 3);
                2:       data_ready_i = 1'($urandom_range(0, 1));
                default: data_ready_i = 1'b1;
            endcase
            idx++;
        end
    end

    // Monitor: whenever a beat is presented it must match the head of the
    // expected queue; it is popped only on a handshake.
    always @(negedge clock_i) begin
        if (!reset_i && data_valid_o) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got data %h with empty queue at %0t", data_o, $time);
            end else begin
                check("beat_data", data_o, exp_q[0].d);
                check("beat_last", 32'(data_last_o), 32'(exp_q[0].last));
                check("beat_pass", 32'(pass_o), 32'(exp_q[0].pass));
                if (data_ready_i) begin
                    void'(exp_q.pop_front());
                    hs_count++;
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(busy_o), 0);
        check({tag, "_load_ready"}, 32'(load_ready_o), 0);
        check({tag, "_max_valid"}, 32'(max_valid_o), 0);
        check({tag, "_max"}, max_o, 0);
        check({tag, "_nan"}, 32'(nan_o), 0);
        check({tag, "_data_valid"}, 32'(data_valid_o), 0);
        check({tag, "_data"}, data_o, 0);
        check({tag, "_last"}, 32'(data_last_o), 0);
        check({tag, "_pass"}, 32'(pass_o), 0);
        check({tag, "_done"}, 32'(done_o), 0);
        check({tag, "_error"}, 32'(error_o), 0);
    endtask

    logic [DW-1:0] exp_max;
    logic          exp_nan;

    task automatic load_vector(input int len, input bit gaps);
        exp_max = 32'hFF80_0000;
        exp_nan = 1'b0;
        for (int i = 0; i < len; i++) begin
            if (is_nan(vec[i])) exp_nan = 1'b1;
            else if (fp_greater(vec[i], exp_max)) exp_max = vec[i];
        end
        for (int p = 0; p < P; p++)
            for (int i = 0; i < len; i++)
                exp_q.push_back('{d: vec[i], last: (i == len - 1), pass: PW'(p)});
        hs_count = 0;
        @(posedge clock_i); #1;
        start_i  = 1'b1;
        length_i = AW'(len);
        @(posedge clock_i); #1;
        start_i = 1'b0;
        check("load_busy", 32'(busy_o), 1);
        check("load_ready", 32'(load_ready_o), 1);
        check("load_max_valid", 32'(max_valid_o), 0);
        for (int i = 0; i < len; i++) begin
            if (gaps) begin
                while ($urandom_range(0, 3) == 0) begin
                    @(posedge clock_i); #1;
                end
            end
            data_valid_i = 1'b1;
            data_i       = vec[i];
            @(posedge clock_i); #1;
            data_valid_i = 1'b0;
        end
        check("max_valid_after_load", 32'(max_valid_o), 1);
        check("max_value", max_o, exp_max);
        check("nan_flag", 32'(nan_o), 32'(exp_nan));
        check("ready_low_after_load", 32'(load_ready_o), 0);
        check("no_early_valid", 32'(data_valid_o), 0);
        @(posedge clock_i); #1;
        check("first_valid_latency", 32'(data_valid_o), 1);
    endtask

    task automatic wait_done(input int len);
        int cyc = 0;
        while (!done_o && cyc < 1000) begin
            @(posedge clock_i); #1;
            cyc++;
        end
        check("done_seen", 32'(done_o), 1);
        check("done_max_hold", max_o, exp_max);
        check("done_max_valid", 32'(max_valid_o), 1);
        check("handshake_count", 32'(hs_count), 32'(len * P));
        check("queue_drained", 32'(exp_q.size()), 0);
        @(posedge clock_i); #1;
        check("done_one_cycle", 32'(done_o), 0);
        check("idle_after_done", 32'(busy_o), 0);
    endtask

    task automatic bad_start(input int len);
        @(posedge clock_i); #1;
        start_i  = 1'b1;
        length_i = AW'(len);
        @(posedge clock_i); #1;
        start_i = 1'b0;
        check("bad_error_pulse", 32'(error_o), 1);
        check("bad_busy", 32'(busy_o), 0);
        check("bad_load_ready", 32'(load_ready_o), 0);
        @(posedge clock_i); #1;
        check("bad_error_clear", 32'(error_o), 0);
    endtask

    initial begin
        logic [DW-1:0] basic [N] = '{32'hC05060D2, 32'h40A5D0A4, 32'hBF3A1674, 32'h401D24F6,
                                     32'hBE3BD70A, 32'h3F461F7D, 32'hC0350DF4, 32'h40BEEE67,
                                     32'hC0A6D2C4, 32'h3F9DF3B6};
        int len;
        int cyc;

        repeat (3) @(posedge clock_i);
        #1;
        check_all_zero("reset");
        reset_i = 1'b0;

        // Basic replay with ready held high
        ready_mode = 0;
        vec = basic;
        load_vector(10, 1'b0);
        wait_done(10);

        // Backpressure with 1,0,0,1 ready pattern
        ready_mode = 1;
        load_vector(10, 1'b0);
        wait_done(10);
        ready_mode = 0;

        // Rejected lengths
        bad_start(0);
        bad_start(11);

        // NaN in the middle
        vec[0] = 32'hC05060D2; vec[1] = 32'h7FC00000; vec[2] = 32'hBF3A1674;
        load_vector(3, 1'b0);
        wait_done(3);

        // Signed zeros
        vec[0] = 32'h80000000; vec[1] = 32'h00000000;
        load_vector(2, 1'b0);
        wait_done(2);

        // Single NaN element
        vec[0] = 32'h7FC00000;
        load_vector(1, 1'b0);
        wait_done(1);

        // Randomised vectors with load gaps and random ready
        ready_mode = 2;
        for (int t = 0; t < 6; t++) begin
            len = (t == 0) ? N : int'($urandom_range(1, N));
            for (int i = 0; i < N; i++) vec[i] = rand_fp();
            load_vector(len, 1'b1);
            wait_done(len);
        end
        ready_mode = 0;

        // Reset in the middle of pass 0
        vec = basic;
        load_vector(10, 1'b0);
        cyc = 0;
        while (hs_count < 4 && cyc < 200) begin
            @(posedge clock_i); #1;
            cyc++;
        end
        check("reached_beat4", 32'(hs_count >= 4), 1);
        reset_i = 1'b1;
        exp_q.delete();
        @(posedge clock_i); #1;
        reset_i = 1'b0;
        check_all_zero("mid_reset");
        vec[0] = 32'h3F800000; vec[1] = 32'hC0000000;
        load_vector(2, 1'b0);
        wait_done(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
